// File: rtl/dmem_lane_serializer.sv
// dmem_lane_serializer
// Funnels the tile's per-lane dmem request channels onto one memory request
// port using round-robin arbitration. Each outgoing request carries its lane
// index in the tag LSBs so the memory response can be steered back to the
// originating lane through a one-entry buffer per lane.
//
// Ports:
//   clock, reset_n         - single clock, synchronous active-low reset
//   dmem_req_*             - per-lane request channels, lane g packed at slice g
//   dmem_resp_*            - per-lane response channels, lane g packed at slice g
//   mem_req_*              - serialized request, tag = {lane tag, lane index}
//   mem_resp_*             - memory responses, lane index taken from tag LSBs
module dmem_lane_serializer #(
  parameter  int NUM_LANES      = 16,
  parameter  int ARCH_LEN       = 32,
  parameter  int DMEM_DATA_BITS = 32,
  parameter  int DMEM_TAG_BITS  = 32,
  localparam int LANE_BITS      = $clog2(NUM_LANES),
  localparam int DMEM_SIZE_BITS = $clog2($clog2(DMEM_DATA_BITS/8)+1),
  localparam int DMEM_MASK_BITS = DMEM_DATA_BITS/8,
  localparam int MEM_TAG_BITS   = DMEM_TAG_BITS + LANE_BITS
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_LANES-1:0]                 dmem_req_valid,
  output logic [NUM_LANES-1:0]                 dmem_req_ready,
  input  logic [NUM_LANES-1:0]                 dmem_req_bits_store,
  input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]   dmem_req_bits_tag,
  input  logic [NUM_LANES*ARCH_LEN-1:0]        dmem_req_bits_address,
  input  logic [NUM_LANES*DMEM_SIZE_BITS-1:0]  dmem_req_bits_size,
  input  logic [NUM_LANES*DMEM_DATA_BITS-1:0]  dmem_req_bits_data,
  input  logic [NUM_LANES*DMEM_MASK_BITS-1:0]  dmem_req_bits_mask,
  output logic [NUM_LANES-1:0]                 dmem_resp_valid,
  input  logic [NUM_LANES-1:0]                 dmem_resp_ready,
  output logic [NUM_LANES*DMEM_TAG_BITS-1:0]   dmem_resp_bits_tag,
  output logic [NUM_LANES*DMEM_DATA_BITS-1:0]  dmem_resp_bits_data,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_bits_store,
  output logic [MEM_TAG_BITS-1:0]              mem_req_bits_tag,
  output logic [ARCH_LEN-1:0]                  mem_req_bits_address,
  output logic [DMEM_SIZE_BITS-1:0]            mem_req_bits_size,
  output logic [DMEM_DATA_BITS-1:0]            mem_req_bits_data,
  output logic [DMEM_MASK_BITS-1:0]            mem_req_bits_mask,
  input  logic                                 mem_resp_valid,
  output logic                                 mem_resp_ready,
  input  logic [MEM_TAG_BITS-1:0]              mem_resp_bits_tag,
  input  logic [DMEM_DATA_BITS-1:0]            mem_resp_bits_data
);

  // Unpacked per-lane views of the packed request/response buses
  logic [DMEM_TAG_BITS-1:0]  req_tag   [NUM_LANES];
  logic [ARCH_LEN-1:0]       req_addr  [NUM_LANES];
  logic [DMEM_SIZE_BITS-1:0] req_size  [NUM_LANES];
  logic [DMEM_DATA_BITS-1:0] req_data  [NUM_LANES];
  logic [DMEM_MASK_BITS-1:0] req_mask  [NUM_LANES];

  logic                      out_valid;
  logic                      out_store;
  logic [MEM_TAG_BITS-1:0]   out_tag;
  logic [ARCH_LEN-1:0]       out_addr;
  logic [DMEM_SIZE_BITS-1:0] out_size;
  logic [DMEM_DATA_BITS-1:0] out_data;
  logic [DMEM_MASK_BITS-1:0] out_mask;
  logic [LANE_BITS-1:0]      rr_ptr;

  logic                      load_en;
  logic                      grant_found;
  logic [LANE_BITS-1:0]      grant_lane;

  logic [NUM_LANES-1:0]      resp_buf_valid;
  logic [DMEM_TAG_BITS-1:0]  resp_tag_q  [NUM_LANES];
  logic [DMEM_DATA_BITS-1:0] resp_data_q [NUM_LANES];
  logic [LANE_BITS-1:0]      resp_lane;
  logic                      resp_fire;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign req_tag[g]  = dmem_req_bits_tag[g*DMEM_TAG_BITS +: DMEM_TAG_BITS];
    assign req_addr[g] = dmem_req_bits_address[g*ARCH_LEN +: ARCH_LEN];
    assign req_size[g] = dmem_req_bits_size[g*DMEM_SIZE_BITS +: DMEM_SIZE_BITS];
    assign req_data[g] = dmem_req_bits_data[g*DMEM_DATA_BITS +: DMEM_DATA_BITS];
    assign req_mask[g] = dmem_req_bits_mask[g*DMEM_MASK_BITS +: DMEM_MASK_BITS];
    assign dmem_resp_bits_tag[g*DMEM_TAG_BITS +: DMEM_TAG_BITS]    = resp_tag_q[g];
    assign dmem_resp_bits_data[g*DMEM_DATA_BITS +: DMEM_DATA_BITS] = resp_data_q[g];
  end

  // The output register can take a new request when empty or being drained.
  assign load_en = !out_valid || mem_req_ready;

  // Round-robin search starting at rr_ptr. NUM_LANES is a power of two, so
  // adding the offset in LANE_BITS arithmetic wraps naturally back to lane 0.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!grant_found && dmem_req_valid[rr_ptr + LANE_BITS'(i)]) begin
        grant_found = 1'b1;
        grant_lane  = rr_ptr + LANE_BITS'(i);
      end
    end
  end

  // Only the granted lane sees ready; reset forces every handshake low.
  always_comb begin
    dmem_req_ready = '0;
    if (reset_n && load_en && grant_found) begin
      dmem_req_ready[grant_lane] = 1'b1;
    end
  end

  // Request output register. The payload is only rewritten on a grant, so
  // it stays stable for as long as the downstream port back-pressures.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_store <= 1'b0;
      out_tag   <= '0;
      out_addr  <= '0;
      out_size  <= '0;
      out_data  <= '0;
      out_mask  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_store <= dmem_req_bits_store[grant_lane];
        out_tag   <= {req_tag[grant_lane], grant_lane};
        out_addr  <= req_addr[grant_lane];
        out_size  <= req_size[grant_lane];
        out_data  <= req_data[grant_lane];
        out_mask  <= req_mask[grant_lane];
        rr_ptr    <= grant_lane + LANE_BITS'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign mem_req_valid        = out_valid && reset_n;
  assign mem_req_bits_store   = out_store;
  assign mem_req_bits_tag     = out_tag;
  assign mem_req_bits_address = out_addr;
  assign mem_req_bits_size    = out_size;
  assign mem_req_bits_data    = out_data;
  assign mem_req_bits_mask    = out_mask;

  // Response acceptance looks only at the target lane named by the tag, so
  // a full buffer on one lane never blocks responses for other lanes. It is
  // deliberately independent of mem_resp_valid.
  assign resp_lane      = mem_resp_bits_tag[LANE_BITS-1:0];
  assign mem_resp_ready = reset_n &&
                          (!resp_buf_valid[resp_lane] || dmem_resp_ready[resp_lane]);
  assign resp_fire      = mem_resp_valid && mem_resp_ready;

  // Per-lane response buffers. A refill takes priority over a drain so that
  // a simultaneous drain and refill leaves the new entry valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_buf_valid <= '0;
      for (int g = 0; g < NUM_LANES; g++) begin
        resp_tag_q[g]  <= '0;
        resp_data_q[g] <= '0;
      end
    end else begin
      for (int g = 0; g < NUM_LANES; g++) begin
        if (resp_fire && (resp_lane == LANE_BITS'(g))) begin
          resp_buf_valid[g] <= 1'b1;
          resp_tag_q[g]     <= mem_resp_bits_tag[MEM_TAG_BITS-1:LANE_BITS];
          resp_data_q[g]    <= mem_resp_bits_data;
        end else if (dmem_resp_ready[g]) begin
          resp_buf_valid[g] <= 1'b0;
        end
      end
    end
  end

  assign dmem_resp_valid = resp_buf_valid & {NUM_LANES{reset_n}};

endmodule

// File: tb/tb_dmem_lane_serializer.sv
// tb_dmem_lane_serializer
// Self-checking bench for dmem_lane_serializer: a table of arbitration
// vectors, hand-written multi-cycle sequences, and a randomized run checked
// against a behavioural model of the lane arbiter and response buffers.
module tb_dmem_lane_serializer;

  localparam int NL = 16;
  localparam int AL = 32;
  localparam int DB = 32;
  localparam int TB = 32;
  localparam int LB = 4;
  localparam int SB = 2;
  localparam int MB = 4;
  localparam int MT = TB + LB;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NL-1:0]     dmem_req_valid;
  logic [NL-1:0]     dmem_req_ready;
  logic [NL-1:0]     dmem_req_bits_store;
  logic [NL*TB-1:0]  dmem_req_bits_tag;
  logic [NL*AL-1:0]  dmem_req_bits_address;
  logic [NL*SB-1:0]  dmem_req_bits_size;
  logic [NL*DB-1:0]  dmem_req_bits_data;
  logic [NL*MB-1:0]  dmem_req_bits_mask;
  logic [NL-1:0]     dmem_resp_valid;
  logic [NL-1:0]     dmem_resp_ready;
  logic [NL*TB-1:0]  dmem_resp_bits_tag;
  logic [NL*DB-1:0]  dmem_resp_bits_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_bits_store;
  logic [MT-1:0]     mem_req_bits_tag;
  logic [AL-1:0]     mem_req_bits_address;
  logic [SB-1:0]     mem_req_bits_size;
  logic [DB-1:0]     mem_req_bits_data;
  logic [MB-1:0]     mem_req_bits_mask;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [MT-1:0]     mem_resp_bits_tag;
  logic [DB-1:0]     mem_resp_bits_data;

  dmem_lane_serializer #(
    .NUM_LANES(NL), .ARCH_LEN(AL), .DMEM_DATA_BITS(DB), .DMEM_TAG_BITS(TB)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .dmem_req_valid        (dmem_req_valid),
    .dmem_req_ready        (dmem_req_ready),
    .dmem_req_bits_store   (dmem_req_bits_store),
    .dmem_req_bits_tag     (dmem_req_bits_tag),
    .dmem_req_bits_address (dmem_req_bits_address),
    .dmem_req_bits_size    (dmem_req_bits_size),
    .dmem_req_bits_data    (dmem_req_bits_data),
    .dmem_req_bits_mask    (dmem_req_bits_mask),
    .dmem_resp_valid       (dmem_resp_valid),
    .dmem_resp_ready       (dmem_resp_ready),
    .dmem_resp_bits_tag    (dmem_resp_bits_tag),
    .dmem_resp_bits_data   (dmem_resp_bits_data),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_req_bits_store    (mem_req_bits_store),
    .mem_req_bits_tag      (mem_req_bits_tag),
    .mem_req_bits_address  (mem_req_bits_address),
    .mem_req_bits_size     (mem_req_bits_size),
    .mem_req_bits_data     (mem_req_bits_data),
    .mem_req_bits_mask     (mem_req_bits_mask),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_ready        (mem_resp_ready),
    .mem_resp_bits_tag     (mem_resp_bits_tag),
    .mem_resp_bits_data    (mem_resp_bits_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // One arbitration step: inputs for the cycle, the ready pattern expected
  // before the edge, and the output register contents expected after it.
  typedef struct {
    logic [NL-1:0] req_valid;
    logic          mem_ready;
    logic [NL-1:0] exp_req_ready;
    logic          exp_out_valid;
    int            exp_lane;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    dmem_req_valid        = '0;
    dmem_req_bits_store   = '0;
    dmem_req_bits_tag     = '0;
    dmem_req_bits_address = '0;
    dmem_req_bits_size    = '0;
    dmem_req_bits_data    = '0;
    dmem_req_bits_mask    = '0;
    dmem_resp_ready       = '0;
    mem_req_ready         = 1'b0;
    mem_resp_valid        = 1'b0;
    mem_resp_bits_tag     = '0;
    mem_resp_bits_data    = '0;
  endtask

  task automatic set_lane(input int g, input logic st, input logic [TB-1:0] tag,
                          input logic [AL-1:0] addr, input logic [SB-1:0] size,
                          input logic [DB-1:0] data, input logic [MB-1:0] mask);
    dmem_req_bits_store[g]             = st;
    dmem_req_bits_tag[g*TB +: TB]      = tag;
    dmem_req_bits_address[g*AL +: AL]  = addr;
    dmem_req_bits_size[g*SB +: SB]     = size;
    dmem_req_bits_data[g*DB +: DB]     = data;
    dmem_req_bits_mask[g*MB +: MB]     = mask;
  endtask

  task automatic send_resp(input logic [TB-1:0] tag, input int lane,
                           input logic [DB-1:0] data);
    mem_resp_valid     = 1'b1;
    mem_resp_bits_tag  = {tag, LB'(lane)};
    mem_resp_bits_data = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    dmem_req_valid = v.req_valid;
    mem_req_ready  = v.mem_ready;
  endtask

  task automatic test_table();
    logic [MT-1:0] etag;
    do_reset();
    for (int g = 0; g < NL; g++)
      set_lane(g, 1'b0, 32'hA000_0000 + 32'(g), 32'h1000 + 32'(g*4), 2'd2,
               32'hD000_0000 + 32'(g), 4'hF);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      settle();
      checkOutput($sformatf("vec%0d req_ready", i), 64'(dmem_req_ready),
                  64'(vecs[i].exp_req_ready));
      tick();
      checkOutput($sformatf("vec%0d out_valid", i), 64'(mem_req_valid),
                  64'(vecs[i].exp_out_valid));
      if (vecs[i].exp_out_valid) begin
        etag = {32'hA000_0000 + 32'(vecs[i].exp_lane), LB'(vecs[i].exp_lane)};
        checkOutput($sformatf("vec%0d tag", i), 64'(mem_req_bits_tag), 64'(etag));
      end
    end
  endtask

  task automatic test_single();
    reset_n = 1'b0;
    clear_inputs();
    dmem_req_valid = '1;
    mem_resp_valid = 1'b1;
    settle();
    checkOutput("reset req_ready", 64'(dmem_req_ready), 64'h0);
    checkOutput("reset mem_resp_ready", 64'(mem_resp_ready), 64'h0);
    tick();
    checkOutput("reset mem_req_valid", 64'(mem_req_valid), 64'h0);
    checkOutput("reset resp_valid", 64'(dmem_resp_valid), 64'h0);
    clear_inputs();
    reset_n = 1'b1;
    set_lane(3, 1'b0, 32'h7, 32'h100, 2'd2, 32'h0, 4'hF);
    dmem_req_valid = 16'h0008;
    mem_req_ready  = 1'b1;
    settle();
    checkOutput("single req_ready", 64'(dmem_req_ready), 64'h0008);
    tick();
    dmem_req_valid = '0;
    checkOutput("single mem_req_valid", 64'(mem_req_valid), 64'h1);
    checkOutput("single tag", 64'(mem_req_bits_tag), 64'h7_3);
    checkOutput("single addr", 64'(mem_req_bits_address), 64'h100);
    tick();
    send_resp(32'hAB, 3, 32'hDEADBEEF);
    settle();
    checkOutput("single mem_resp_ready", 64'(mem_resp_ready), 64'h1);
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("single resp_valid", 64'(dmem_resp_valid), 64'h0008);
    checkOutput("single resp tag", 64'(dmem_resp_bits_tag[3*TB +: TB]), 64'hAB);
    checkOutput("single resp data", 64'(dmem_resp_bits_data[3*DB +: DB]), 64'hDEADBEEF);
    dmem_resp_ready = 16'h0008;
    tick();
    checkOutput("single drained", 64'(dmem_resp_valid), 64'h0);
  endtask

  task automatic test_fair();
    do_reset();
    for (int g = 0; g < NL; g++)
      set_lane(g, 1'b0, 32'(g), 32'(g), 2'd2, 32'(g), 4'hF);
    dmem_req_valid = '1;
    mem_req_ready  = 1'b1;
    for (int c = 0; c < 17; c++) begin
      settle();
      checkOutput($sformatf("fair%0d req_ready", c), 64'(dmem_req_ready),
                  64'(1) << (c % NL));
      tick();
      checkOutput($sformatf("fair%0d lane", c), 64'(mem_req_bits_tag[LB-1:0]),
                  64'(c % NL));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lane(2, 1'b0, 32'h22, 32'h2000, 2'd2, 32'h2222, 4'hF);
    set_lane(5, 1'b0, 32'h55, 32'h5000, 2'd2, 32'h5555, 4'hF);
    dmem_req_valid = 16'h0024;
    mem_req_ready  = 1'b0;
    settle();
    checkOutput("bp first grant", 64'(dmem_req_ready), 64'h0004);
    tick();
    dmem_req_valid = 16'h0020;
    for (int c = 0; c < 5; c++) begin
      settle();
      checkOutput($sformatf("bp%0d req_ready", c), 64'(dmem_req_ready), 64'h0);
      checkOutput($sformatf("bp%0d hold", c),
                  {27'h0, mem_req_valid, mem_req_bits_address},
                  {27'h0, 1'b1, 32'h2000});
      tick();
    end
    mem_req_ready = 1'b1;
    settle();
    checkOutput("bp release grant", 64'(dmem_req_ready), 64'h0020);
    tick();
    dmem_req_valid = '0;
    checkOutput("bp lane5 issued", 64'(mem_req_bits_tag), 64'h55_5);
  endtask

  task automatic test_resp_buf();
    do_reset();
    dmem_resp_ready = 16'hFFFD;
    send_resp(32'h11, 1, 32'h1111);
    settle();
    checkOutput("rb first ready", 64'(mem_resp_ready), 64'h1);
    tick();
    send_resp(32'h22, 1, 32'h2222);
    settle();
    checkOutput("rb second blocked", 64'(mem_resp_ready), 64'h0);
    checkOutput("rb held data", 64'(dmem_resp_bits_data[1*DB +: DB]), 64'h1111);
    tick();
    send_resp(32'h44, 4, 32'h4444);
    settle();
    checkOutput("rb lane4 ready", 64'(mem_resp_ready), 64'h1);
    tick();
    checkOutput("rb lane4 valid", 64'(dmem_resp_valid), 64'h0012);
    send_resp(32'h22, 1, 32'h2222);
    settle();
    checkOutput("rb still blocked", 64'(mem_resp_ready), 64'h0);
    dmem_resp_ready = 16'hFFFF;
    settle();
    checkOutput("rb drain ready", 64'(mem_resp_ready), 64'h1);
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("rb refill valid", 64'(dmem_resp_valid), 64'h0002);
    checkOutput("rb refill entry",
                {dmem_resp_bits_tag[1*TB +: TB], dmem_resp_bits_data[1*DB +: DB]},
                {32'h22, 32'h2222});
    tick();
    checkOutput("rb empty", 64'(dmem_resp_valid), 64'h0);
  endtask

  task automatic test_store();
    do_reset();
    set_lane(0, 1'b1, 32'h5A, 32'h40, 2'd2, 32'h1234, 4'b0011);
    dmem_req_valid = 16'h0001;
    mem_req_ready  = 1'b1;
    settle();
    checkOutput("store req_ready", 64'(dmem_req_ready), 64'h1);
    tick();
    dmem_req_valid = '0;
    checkOutput("store fields",
                {27'h0, mem_req_bits_store, mem_req_bits_mask, mem_req_bits_data},
                {27'h0, 1'b1, 4'b0011, 32'h1234});
    checkOutput("store tag", 64'(mem_req_bits_tag), 64'h5A_0);
    send_resp(32'h5A, 0, 32'h0);
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("store resp", {31'h0, dmem_resp_valid[0], dmem_resp_bits_tag[0 +: TB]},
                {31'h0, 1'b1, 32'h5A});
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_lane(9, 1'b0, 32'h99, 32'h9000, 2'd2, 32'h9999, 4'hF);
    dmem_req_valid = 16'h0200;
    send_resp(32'h66, 6, 32'h6);
    tick();
    send_resp(32'h77, 7, 32'h7);
    tick();
    send_resp(32'h88, 8, 32'h8);
    tick();
    send_resp(32'hAA, 10, 32'hA);
    settle();
    checkOutput("rm buffered", 64'(dmem_resp_valid), 64'h01C0);
    checkOutput("rm out_valid", 64'(mem_req_valid), 64'h1);
    reset_n = 1'b0;
    settle();
    checkOutput("rm resp_ready in reset", 64'(mem_resp_ready), 64'h0);
    tick();
    checkOutput("rm valids cleared",
                {mem_req_valid, dmem_resp_valid, dmem_req_ready}, 33'h0);
    mem_resp_valid = 1'b0;
    for (int g = 0; g < NL; g++)
      set_lane(g, 1'b0, 32'(g), 32'(g), 2'd2, 32'(g), 4'hF);
    dmem_req_valid = '1;
    mem_req_ready  = 1'b1;
    reset_n        = 1'b1;
    settle();
    checkOutput("rm first grant lane0", 64'(dmem_req_ready), 64'h1);
    tick();
    checkOutput("rm issued lane0", 64'(mem_req_bits_tag), 64'h0_0);
  endtask

  // Reference model state: the pending outgoing request, the arbiter start
  // lane, and one buffered response per lane.
  bit            m_out_valid;
  logic [MT-1:0] m_tag;
  logic [AL-1:0] m_addr;
  logic [DB-1:0] m_data;
  logic [6:0]    m_ctl;
  int            m_rr;
  bit            m_bv [NL];
  logic [TB-1:0] m_bt [NL];
  logic [DB-1:0] m_bd [NL];

  task automatic run_random();
    int            grant;
    int            rl;
    bit            exp_mrr;
    bit            load;
    logic [NL-1:0] exp_ready;
    logic [NL-1:0] exp_rv;
    do_reset();
    m_out_valid = 0;
    m_rr        = 0;
    for (int g = 0; g < NL; g++) m_bv[g] = 0;
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      dmem_req_valid = ($urandom_range(0, 3) == 0) ? NL'($urandom)
                     : NL'($urandom) & NL'($urandom) & NL'($urandom);
      for (int g = 0; g < NL; g++)
        set_lane(g, 1'($urandom), $urandom, $urandom, 2'($urandom), $urandom,
                 4'($urandom));
      mem_req_ready   = ($urandom_range(0, 3) != 0);
      mem_resp_valid  = 1'($urandom);
      mem_resp_bits_tag  = {32'($urandom), 4'($urandom)};
      mem_resp_bits_data = $urandom;
      dmem_resp_ready = NL'($urandom) | NL'($urandom);
      settle();

      load  = reset_n && (!m_out_valid || mem_req_ready);
      grant = -1;
      if (load)
        for (int k = 0; k < NL; k++)
          if (grant < 0 && dmem_req_valid[(m_rr + k) % NL]) grant = (m_rr + k) % NL;
      exp_ready = '0;
      if (grant >= 0) exp_ready[grant] = 1'b1;
      rl      = int'(mem_resp_bits_tag[LB-1:0]);
      exp_mrr = reset_n && (!m_bv[rl] || dmem_resp_ready[rl]);
      exp_rv  = '0;
      for (int g = 0; g < NL; g++) exp_rv[g] = reset_n && m_bv[g];

      checkOutput("rnd req_ready", 64'(dmem_req_ready), 64'(exp_ready));
      checkOutput("rnd mem_resp_ready", 64'(mem_resp_ready), 64'(exp_mrr));
      checkOutput("rnd mem_req_valid", 64'(mem_req_valid), 64'(reset_n && m_out_valid));
      checkOutput("rnd resp_valid", 64'(dmem_resp_valid), 64'(exp_rv));
      if (reset_n && m_out_valid) begin
        checkOutput("rnd req tag", 64'(mem_req_bits_tag), 64'(m_tag));
        checkOutput("rnd req addr/data", {mem_req_bits_address, mem_req_bits_data},
                    {m_addr, m_data});
        checkOutput("rnd req ctl",
                    64'({mem_req_bits_store, mem_req_bits_size, mem_req_bits_mask}),
                    64'(m_ctl));
      end
      for (int g = 0; g < NL; g++)
        if (exp_rv[g])
          checkOutput($sformatf("rnd resp lane%0d", g),
                      {dmem_resp_bits_tag[g*TB +: TB], dmem_resp_bits_data[g*DB +: DB]},
                      {m_bt[g], m_bd[g]});

      if (!reset_n) begin
        m_out_valid = 0;
        m_rr        = 0;
        for (int g = 0; g < NL; g++) m_bv[g] = 0;
      end else begin
        if (grant >= 0) begin
          m_out_valid = 1;
          m_tag  = {dmem_req_bits_tag[grant*TB +: TB], LB'(grant)};
          m_addr = dmem_req_bits_address[grant*AL +: AL];
          m_data = dmem_req_bits_data[grant*DB +: DB];
          m_ctl  = {dmem_req_bits_store[grant], dmem_req_bits_size[grant*SB +: SB],
                    dmem_req_bits_mask[grant*MB +: MB]};
          m_rr   = (grant + 1) % NL;
        end else if (load) begin
          m_out_valid = 0;
        end
        for (int g = 0; g < NL; g++)
          if (m_bv[g] && dmem_resp_ready[g]) m_bv[g] = 0;
        if (mem_resp_valid && exp_mrr) begin
          m_bv[rl] = 1;
          m_bt[rl] = mem_resp_bits_tag[MT-1:LB];
          m_bd[rl] = mem_resp_bits_data;
        end
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h0008, 1'b1, 16'h0008, 1'b1, 3};
    vecs[1] = '{16'h0009, 1'b1, 16'h0001, 1'b1, 0};
    vecs[2] = '{16'h0009, 1'b0, 16'h0000, 1'b1, 0};
    vecs[3] = '{16'h0009, 1'b1, 16'h0008, 1'b1, 3};
    vecs[4] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 0};
    vecs[5] = '{16'h8000, 1'b0, 16'h8000, 1'b1, 15};
    vecs[6] = '{16'h8001, 1'b1, 16'h0001, 1'b1, 0};
    vecs[7] = '{16'hFFFF, 1'b1, 16'h0002, 1'b1, 1};
    vecs[8] = '{16'h0004, 1'b1, 16'h0004, 1'b1, 2};

    clear_inputs();
    test_single();
    test_table();
    test_fair();
    test_backpressure();
    test_resp_buf();
    test_store();
    test_reset_mid();
    run_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lane_serializer.md
Name: dmem_lane_serializer

Overview:
- Sits directly downstream of the Cyclotron tile's per-lane dmem ports.
- Arbitrates the NUM_LANES load/store request channels onto a single memory request port, round-robin.
- Tags each request with its lane index, and routes memory responses back to the originating lane through per-lane 1-entry response buffers.
- Gives the tile's vector dmem interface a scalar path to one cache or TileLink client.

Parameters:
- NUM_LANES, 16, number of dmem lanes (power of two, >=2)
- ARCH_LEN, 32, address width
- DMEM_DATA_BITS, 32, per-lane data width
- DMEM_TAG_BITS, 32, per-lane tag width
- LANE_BITS, $clog2(NUM_LANES), lane index width (localparam)
- DMEM_SIZE_BITS, $clog2($clog2(DMEM_DATA_BITS/8)+1), size field width (localparam)
- DMEM_MASK_BITS, DMEM_DATA_BITS/8, byte mask width (localparam)

Ports:
- clock  in  1  single clock
- reset_n  in  1  synchronous reset, active-low
- dmem_req_valid  in  NUM_LANES  per-lane request valid
- dmem_req_ready  out  NUM_LANES  per-lane request accept
- dmem_req_bits_store  in  NUM_LANES  1 = store
- dmem_req_bits_tag  in  NUM_LANES*DMEM_TAG_BITS  packed, lane g at [g*DMEM_TAG_BITS +: DMEM_TAG_BITS]
- dmem_req_bits_address  in  NUM_LANES*ARCH_LEN  packed
- dmem_req_bits_size  in  NUM_LANES*DMEM_SIZE_BITS  packed, log2 bytes
- dmem_req_bits_data  in  NUM_LANES*DMEM_DATA_BITS  packed
- dmem_req_bits_mask  in  NUM_LANES*DMEM_MASK_BITS  packed
- dmem_resp_valid  out  NUM_LANES  per-lane response valid
- dmem_resp_ready  in  NUM_LANES  per-lane response accept
- dmem_resp_bits_tag  out  NUM_LANES*DMEM_TAG_BITS  packed
- dmem_resp_bits_data  out  NUM_LANES*DMEM_DATA_BITS  packed
- mem_req_valid  out  1  serialized request valid
- mem_req_ready  in  1  downstream accept
- mem_req_bits_store  out  1
- mem_req_bits_tag  out  DMEM_TAG_BITS+LANE_BITS  {lane tag, lane index}; lane index in LSBs
- mem_req_bits_address  out  ARCH_LEN
- mem_req_bits_size  out  DMEM_SIZE_BITS
- mem_req_bits_data  out  DMEM_DATA_BITS
- mem_req_bits_mask  out  DMEM_MASK_BITS
- mem_resp_valid  in  1
- mem_resp_ready  out  1
- mem_resp_bits_tag  in  DMEM_TAG_BITS+LANE_BITS
- mem_resp_bits_data  in  DMEM_DATA_BITS

Behaviour:
- Reset (reset_n=0 at posedge):
  - out_valid=0, all resp_buf_valid=0, rr_ptr=0, all payload registers 0.
  - During reset, mem_req_valid=0, dmem_resp_valid=0, dmem_req_ready=0.
  - mem_resp_ready=0 whenever reset_n=0.
  - Reset mid-transaction drops buffered requests and responses; no replay.
- Request path:
  - One output register (out_valid plus payload) drives mem_req_*.
  - load_en = !out_valid || mem_req_ready.
  - When load_en=1, grant the first lane with dmem_req_valid=1, searching from rr_ptr upward and wrapping at NUM_LANES-1 -> 0.
  - dmem_req_ready[g] = load_en && (g == granted lane); at most one bit is high.
  - On grant:
    - Register the payload; mem_req_bits_tag = {lane tag, g}.
    - out_valid <= 1.
    - rr_ptr <= (g+1) mod NUM_LANES.
  - If load_en=1 and no lane is valid: out_valid <= 0, rr_ptr unchanged.
  - If out_valid=1 and mem_req_ready=0: hold the payload stable; all dmem_req_ready=0.
  - Latency: accepted at edge N -> mem_req_valid at N+1.
  - Throughput: 1 request/cycle when mem_req_ready is held at 1.
- Response path:
  - l = mem_resp_bits_tag[LANE_BITS-1:0].
  - mem_resp_ready = !resp_buf_valid[l] || dmem_resp_ready[l]. This is combinational on the tag and must not depend on mem_resp_valid.
  - On mem_resp fire:
    - resp_buf[l] <= {mem_resp_bits_tag[DMEM_TAG_BITS+LANE_BITS-1:LANE_BITS], data}.
    - resp_buf_valid[l] <= 1.
  - dmem_resp_valid[g] = resp_buf_valid[g]; dmem_resp_bits_* come from resp_buf[g].
  - When dmem_resp fires on lane g with no simultaneous refill: resp_buf_valid[g] <= 0.
  - Simultaneous drain and refill on the same lane: the buffer takes the new entry and valid stays 1.
  - Latency: mem_resp fire at edge N -> dmem_resp_valid at N+1.
- Responses:
  - Stores and loads both receive exactly one response.
  - The block does not reorder within the memory response stream and imposes no outstanding limit.
- Request and response paths are independent; a full response buffer never stalls the request path.

Test Plan:
- Single lane: reset, lane 3 load addr 0x100, tag 0x7, mem_req_ready=1.
  - Required: mem_req_valid the next cycle with tag {0x7,4'd3}.
  - Then mem_resp tag {0xAB,4'd3}, data 0xDEADBEEF -> lane 3 dmem_resp_valid the next cycle with tag 0xAB, data 0xDEADBEEF.
- Fairness: all 16 lanes valid continuously, mem_req_ready=1.
  - Required: grants go 0,1,...,15,0 with one per cycle, and dmem_req_ready is one-hot each cycle.
- Backpressure: hold mem_req_ready=0 for 5 cycles with lanes 2 and 5 valid.
  - Required: mem_req payload stable at lane 2, dmem_req_ready=0.
  - After release: lane 5 issues on the next cycle.
- Response buffering: lane 1 dmem_resp_ready=0, two mem_resps for lane 1.
  - First response is buffered; mem_resp_ready=0 while the second is presented.
  - A response tagged for lane 4 in the same period is accepted.
  - Raising dmem_resp_ready[1] drains and refills in the same cycle.
- Store: lane 0 store, mask 4'b0011, data 0x1234.
  - Required: mem_req_bits_store=1 with mask and data intact; the response is delivered to lane 0.
- Reset mid-operation: assert reset_n=0 with out_valid=1 and 3 buffered responses.
  - Required: next cycle all valids 0 and mem_resp_ready=0; after release, the first grant starts at lane 0.
